sram_dp_be: RTL and testbench
=============================

# sram_dp_be

Parametrised single-clock, dual-port (one write, one read) SRAM with byte-enable writes, a configurable read latency with a valid strobe, and a sequential hardware clear engine. It replaces reset-time array clearing in the NPU activation and weight buffers. The clear runs after reset and on request, one word per cycle. It sits between the DMA write path (port A) and the PE-array read path (port B).

## Interface
- DATA_W, 128, word width in bits; must be a multiple of 8
- ADDR_W, 12, address width
- DEPTH, 4096, number of words; must satisfy DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2
- BE_W, DATA_W/8, byte-enable width (derived, not overridable)

Ports:
- clka  in  1  clock for both ports
- rstn  in  1  asynchronous reset, active-low
- clr_req  in  1  pulse; starts a full-array clear
- clr_busy  out  1  clear engine active
- ena  in  1  write-port enable
- wea  in  1  write enable
- bea  in  BE_W  byte enables; bit k covers dina[8k+7:8k]
- addra  in  ADDR_W  write address
- dina  in  DATA_W  write data
- wr_drop  out  1  one-cycle pulse; a write was discarded
- enb  in  1  read enable
- addrb  in  ADDR_W  read address
- doutb  out  DATA_W  read data
- doutb_vld  out  1  doutb valid for one cycle

## Operation
- Write accepted when ena & wea & !clr_busy & addra < DEPTH.
  - Only bytes with bea[k]=1 are updated.
  - bea = 0 is a legal no-op and is not counted as a drop.
- wr_drop pulses on the cycle after a write that is requested but discarded, either because clr_busy=1 or because addra ≥ DEPTH.
- Read issued when enb=1.
  - doutb_vld pulses RD_LAT cycles later.
  - When enb=0, doutb holds its last value.
- Read returns zero (doutb_vld still pulses) when:
  - addrb ≥ DEPTH, or
  - the read was issued while clr_busy=1.
- Same-cycle write and read to the same address is read-first: the read returns the old word (but see Configuration).
- Clear FSM:
  - States CLEAR and IDLE. Reset forces CLEAR with counter clr_addr=0.
  - CLEAR: each cycle writes 0 to ram[clr_addr] and increments clr_addr. When clr_addr = DEPTH-1 is written, the FSM moves to IDLE.
  - IDLE: clr_req=1 moves to CLEAR with clr_addr=0.
  - clr_req while in CLEAR is ignored; there is no restart.
- clr_busy = (state == CLEAR).
- Reset mid-clear restarts the clear from address 0.

## Timing
- Reset values:
  - clr_busy=1, state CLEAR, clr_addr=0
  - doutb=0, doutb_vld=0, wr_drop=0
  - RD_LAT=2 pipeline stage = 0
- First rising clka edge after rstn deasserts clears address 0.
  - Edge number DEPTH clears DEPTH-1, and clr_busy is low after that edge.
  - A clear therefore occupies exactly DEPTH cycles.
- clr_req sampled at edge n in IDLE: clr_busy high after edge n, and address 0 is cleared at edge n+1.
- A write sampled at edge n is visible to a read sampled at edge n+1 or later.
- RD_LAT=1: read sampled at edge n gives doutb/doutb_vld after edge n.
  - RD_LAT=2: after edge n+1.
  - Back-to-back reads every cycle are supported, with full throughput.
- wr_drop is registered: high after the edge that sampled the discarded write.

## Configuration
- Macro SRAM_WR_FWD_EN.
- Defined: on a same-cycle write and read to the same address with an accepted write, doutb returns new bytes where bea=1 and old bytes elsewhere (write-first with byte merge). Latency is unchanged.
- Undefined: read-first, as in Operation; no forwarding logic is generated.

## Test plan
- Reset then idle, DEPTH=16: clr_busy stays high for 16 cycles then falls. Reading addresses 0..15 afterwards returns 0 with one doutb_vld pulse each.
- Write 0xA5 pattern to addr 3 with bea all ones, then write 0x5A to addr 3 with bea=0x0001, then read addr 3. Byte 0 = 0x5A and all other bytes = 0xA5. Check at RD_LAT=1 and RD_LAT=2, with doutb_vld exactly RD_LAT cycles after enb.
- Write during the post-reset clear: wr_drop pulses once and the target word reads back 0 after clear. A write to addra=DEPTH also pulses wr_drop.
- Same-cycle write 0xFFFF… and read to addr 7, which previously held 0x1234:
  - without SRAM_WR_FWD_EN, the read returns 0x1234;
  - with the macro, it returns 0xFFFF….
- Fill all addresses, pulse clr_req, then pulse clr_req again 5 cycles later: busy lasts exactly DEPTH cycles from the first pulse and all words read 0 afterwards.
- Assert rstn low mid-clear at clr_addr=9: outputs go to reset values immediately, and the clear restarts at address 0 and takes a full DEPTH cycles.

Source files
------------

// File: rtl/sram_dp_be.sv
// Dual-port (1W/1R) SRAM with byte-enable writes, RD_LAT 1/2 read pipeline with valid
// strobe and a sequential clear engine. Optional macro SRAM_WR_FWD_EN enables write-first forwarding.
module sram_dp_be #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              ena,
  input  logic              wea,
  input  logic [BE_W-1:0]   bea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic              wr_drop,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              doutb_vld
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_req, wr_in_range, wr_ok;
  logic              rd_zero;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign clr_busy    = (state == CLEAR);
  assign wr_idx      = addra[IDX_W-1:0];
  assign rd_idx      = addrb[IDX_W-1:0];
  assign wr_in_range = ({1'b0, addra} < DEPTH_L);
  // An all-zero byte mask is a no-op rather than a request, so it can never be dropped.
  assign wr_req      = ena & wea & (|bea);
  assign wr_ok       = wr_req & ~clr_busy & wr_in_range;
  assign rd_zero     = clr_busy | ({1'b0, addrb} >= DEPTH_L);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state    <= CLEAR;
      clr_addr <= '0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_req & ~wr_ok;
      case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // NOTE: the array has no reset; the clear engine zeroes it one word per cycle instead.
  always_ff @(posedge clka) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < BE_W; k++) begin
        if (bea[k]) mem[wr_idx][8*k +: 8] <= dina[8*k +: 8];
      end
    end
  end

  // NOTE: rd_word gets a default first so no path through this block infers a latch.
  always_comb begin
    rd_word = '0;
    if (!rd_zero) begin
      rd_word = mem[rd_idx];
`ifdef SRAM_WR_FWD_EN
      if (wr_ok && (addra == addrb)) begin
        for (int k = 0; k < BE_W; k++) begin
          if (bea[k]) rd_word[8*k +: 8] = dina[8*k +: 8];
        end
      end
`endif
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
          doutb     <= '0;
          doutb_vld <= 1'b0;
        end else begin
          doutb_vld <= enb;
          if (enb) doutb <= rd_word;
        end
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic              s1_vld;
      always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
          s1_data   <= '0;
          s1_vld    <= 1'b0;
          doutb     <= '0;
          doutb_vld <= 1'b0;
        end else begin
          s1_vld    <= enb;
          doutb_vld <= s1_vld;
          if (enb)    s1_data <= rd_word;
          if (s1_vld) doutb   <= s1_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_be.sv
// Directed bench for sram_dp_be: one RD_LAT=1 and one RD_LAT=2 instance share stimulus;
// the RD_LAT=2 outputs are expected one cycle behind the RD_LAT=1 expectations.
module tb_sram_dp_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int BE_W   = DATA_W / 8;

`ifdef SRAM_WR_FWD_EN
  localparam logic [31:0] SAME_RD = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SAME_RD = 32'h0000_1234;
`endif

  logic              clka = 1'b0;
  logic              rstn;
  logic              clr_req, ena, wea, enb;
  logic [BE_W-1:0]   bea;
  logic [ADDR_W-1:0] addra, addrb;
  logic [DATA_W-1:0] dina;

  logic              busy1, busy2, drop1, drop2, vld1, vld2;
  logic [DATA_W-1:0] dout1, dout2;

  int checks   = 0;
  int failures = 0;

  always #5 clka = ~clka;

  sram_dp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1)) u1 (
    .clka(clka), .rstn(rstn), .clr_req(clr_req), .clr_busy(busy1),
    .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina), .wr_drop(drop1),
    .enb(enb), .addrb(addrb), .doutb(dout1), .doutb_vld(vld1));

  sram_dp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2)) u2 (
    .clka(clka), .rstn(rstn), .clr_req(clr_req), .clr_busy(busy2),
    .ena(ena), .wea(wea), .bea(bea), .addra(addra), .dina(dina), .wr_drop(drop2),
    .enb(enb), .addrb(addrb), .doutb(dout2), .doutb_vld(vld2));

  typedef struct {
    logic        ena, wea;
    logic [3:0]  bea;
    logic [4:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [4:0]  addrb;
    logic        exp_drop, exp_vld;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; ena = 1'b0; wea = 1'b0; bea = '0;
    addra = '0; dina = '0; enb = 1'b0; addrb = '0;
  endtask

  task automatic write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    ena = 1'b1; wea = 1'b1; bea = be; addra = a; dina = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy1"}, 32'(busy1), 32'd1);
    check({tag, "_busy2"}, 32'(busy2), 32'd1);
    check({tag, "_drop1"}, 32'(drop1), 32'd0);
    check({tag, "_vld1"},  32'(vld1),  32'd0);
    check({tag, "_vld2"},  32'(vld2),  32'd0);
    check({tag, "_dout1"}, dout1, 32'd0);
    check({tag, "_dout2"}, dout2, 32'd0);
  endtask

  // Counts edges until clr_busy falls; cnt_in is the number of edges already taken.
  task automatic wait_clear(input string name, input int cnt_in);
    int cnt = cnt_in;
    while (busy1 && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, 32'(cnt), 32'(DEPTH));
    check({name, "_rd2"}, 32'(busy2), 32'd0);
  endtask

  // Back-to-back reads of lo..hi, all expected to return exp.
  task automatic read_range(input string name, input int lo, input int hi, input logic [31:0] exp);
    for (int i = lo; i <= hi + 1; i++) begin
      enb   = (i <= hi);
      addrb = 5'(i);
      tick();
      if (i <= hi) begin
        check({name, "_vld1"}, 32'(vld1), 32'd1);
        check({name, "_dout1"}, dout1, exp);
      end else begin
        check({name, "_vld1_end"}, 32'(vld1), 32'd0);
      end
      if (i > lo) begin
        check({name, "_vld2"}, 32'(vld2), 32'd1);
        check({name, "_dout2"}, dout2, exp);
      end
    end
    enb = 1'b0;
    tick();
  endtask

  initial begin
    logic        prev_vld;
    logic [31:0] prev_dout;

    vecs[0]  = '{1'b1, 1'b1, 4'hF, 5'd3,  32'hA5A5_A5A5, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 4'h1, 5'd3,  32'h5A5A_5A5A, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 1'b1, 32'hA5A5_A55A};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 32'hA5A5_A55A};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 5'd7,  32'h0000_1234, 1'b0, 5'd0,  1'b0, 1'b0, 32'hA5A5_A55A};
    vecs[5]  = '{1'b1, 1'b1, 4'hF, 5'd7,  32'hFFFF_FFFF, 1'b1, 5'd7,  1'b0, 1'b1, SAME_RD};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 5'd16, 32'h1111_1111, 1'b1, 5'd16, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 4'h0, 5'd3,  32'h0,         1'b1, 5'd5,  1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 4'hC, 5'd10, 32'hAABB_CCDD, 1'b1, 5'd3,  1'b0, 1'b1, 32'hA5A5_A55A};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'hAABB_0000};
    vecs[12] = '{1'b1, 1'b0, 4'hF, 5'd10, 32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'hAABB_0000};
    vecs[13] = '{1'b0, 1'b1, 4'hF, 5'd10, 32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'hAABB_0000};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd10, 1'b0, 1'b1, 32'hAABB_0000};

    idle_inputs();
    rstn = 1'b0;
    #12;
    check_reset_outputs("reset");

    // Post-reset clear, with a write to addr 5 landing inside it.
    @(negedge clka);
    rstn = 1'b1;
    tick();
    write(5'd5, 4'hF, 32'hDEAD_BEEF);
    tick();
    idle_inputs();
    check("drop_in_clear", 32'(drop1), 32'd1);
    tick();
    check("drop_once", 32'(drop1), 32'd0);
    wait_clear("post_reset_busy", 3);

    read_range("after_reset", 0, DEPTH - 1, 32'h0);

    // Table vectors; RD_LAT=2 expectations trail the RD_LAT=1 ones by one cycle.
    prev_vld  = 1'b0;
    prev_dout = 32'h0;
    for (int i = 0; i < 15; i++) begin
      ena = vecs[i].ena; wea = vecs[i].wea; bea = vecs[i].bea;
      addra = vecs[i].addra; dina = vecs[i].dina;
      enb = vecs[i].enb; addrb = vecs[i].addrb;
      tick();
      check($sformatf("vec%0d_drop", i), 32'(drop1), 32'(vecs[i].exp_drop));
      check($sformatf("vec%0d_vld1", i), 32'(vld1), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_dout1", i), dout1, vecs[i].exp_dout);
      check($sformatf("vec%0d_vld2", i), 32'(vld2), 32'(prev_vld));
      check($sformatf("vec%0d_dout2", i), dout2, prev_dout);
      prev_vld  = vecs[i].exp_vld;
      prev_dout = vecs[i].exp_dout;
    end
    idle_inputs();
    tick();
    tick();

    // Fill, then clr_req with a second ignored request five cycles later.
    for (int i = 0; i < DEPTH; i++) begin
      write(5'(i), 4'hF, 32'h0101_0101 * 32'(i + 1));
      tick();
      check($sformatf("fill%0d_drop", i), 32'(drop1), 32'd0);
    end
    idle_inputs();
    read_range("fill_last", DEPTH - 1, DEPTH - 1, 32'h1010_1010);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_req_busy", 32'(busy1), 32'd1);
    begin
      int cnt = 0;
      while (busy1 && cnt < 100) begin
        clr_req = (cnt == 4);
        tick();
        cnt++;
      end
      clr_req = 1'b0;
      check("clr_req_busy_cycles", 32'(cnt), 32'(DEPTH));
    end
    read_range("after_clr", 0, DEPTH - 1, 32'h0);

    // Reset asserted at clr_addr=9 with outputs non-zero.
    write(5'd15, 4'hF, 32'h0000_0077);
    tick();
    idle_inputs();
    read_range("pre_rst", DEPTH - 1, DEPTH - 1, 32'h0000_0077);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (8) tick();
    write(5'd2, 4'hF, 32'h1);
    enb = 1'b1;
    addrb = 5'd4;
    tick();
    idle_inputs();
    check("mid_clr_drop", 32'(drop1), 32'd1);
    check("mid_clr_vld1", 32'(vld1), 32'd1);
    check("mid_clr_dout2", dout2, 32'h0000_0077);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clka);
    rstn = 1'b1;
    wait_clear("restart_busy", 0);
    read_range("after_restart", 0, DEPTH - 1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
